// File: rtl/tri_pkg.sv
// Shared types and default geometry for the triangular skew feeder.
package tri_pkg;

  localparam int DEF_BIT_WIDTH  = 32;
  localparam int DEF_TRI_LENGTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/tri_skew_feeder_skew_lane.sv
// One lane of the skew: enable and data delayed together by DEPTH cycles,
// with data forced to zero whenever enable is low.
module skew_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  en_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DEPTH-1:0]                 en_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;

  // NOTE: every delay stage is reset, so a reset mid-tile flushes in-flight
  // elements instead of letting them emerge after release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q   <= '0;
      data_q <= '0;
    end else begin
      en_q[0]   <= en_i;
      data_q[0] <= en_i ? data_i : '0;
      for (int k = 1; k < DEPTH; k++) begin
        en_q[k]   <= en_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

  assign en_o   = en_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/tri_skew_feeder.sv
// Turns one unskewed row vector per accept into a diagonal wavefront:
// lane i emits its element i+1 cycles after the accept. Tiles end on in_last.
module tri_skew_feeder
  import tri_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int TRI_LENGTH = DEF_TRI_LENGTH
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_last,
  input  logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] in_data,
  output logic [TRI_LENGTH-1:0]                enable_out,
  output logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] data_out,
  output logic                                 busy,
  output logic                                 done
);

  localparam int               CNT_W    = (TRI_LENGTH > 1) ? $clog2(TRI_LENGTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TRI_LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             done_q;
  logic             accept;

  assign accept = in_valid && ready_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            if (!in_last) begin
              state_q <= STREAM;
            end else if (TRI_LENGTH == 1) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
              cnt_q   <= CNT_LOAD;
              ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          cnt_q <= cnt_q - CNT_LAST;
          // The last lane's final element lands in the cycle after count 1.
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = ready_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  for (genvar i = 0; i < TRI_LENGTH; i++) begin : g_lane
    skew_lane #(
      .DATA_WIDTH(BIT_WIDTH),
      .DEPTH     (i + 1)
    ) u_lane (
      .clk   (clk),
      .rstn  (rstn),
      .en_i  (accept),
      .data_i(in_data[i]),
      .en_o  (enable_out[i]),
      .data_o(data_out[i])
    );
  end

endmodule

// File: tb/tb_tri_skew_feeder.sv
// Bench for tri_skew_feeder: a 4-lane instance checked against a transaction
// schedule model, plus a directed look at a 1-lane build.
module tb_tri_skew_feeder;

  localparam int L    = 4;
  localparam int W    = 32;
  localparam int NCYC = 1024;
  localparam int NEVER = 1 << 30;

  typedef logic [L-1:0][W-1:0] vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-lane DUT
  logic         rstn;
  logic         in_valid, in_last, in_ready, busy, done;
  vec_t         in_data;
  logic [L-1:0] enable_out;
  vec_t         data_out;

  tri_skew_feeder #(.BIT_WIDTH(W), .TRI_LENGTH(L)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_data   (in_data),
    .enable_out(enable_out),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  // 1-lane DUT
  logic          rstn1, v1, l1, r1, busy1, done1;
  logic [0:0][W-1:0] d1, do1;
  logic [0:0]    en1;

  tri_skew_feeder #(.BIT_WIDTH(W), .TRI_LENGTH(1)) dut1 (
    .clk       (clk),
    .rstn      (rstn1),
    .in_valid  (v1),
    .in_ready  (r1),
    .in_last   (l1),
    .in_data   (d1),
    .enable_out(en1),
    .data_out  (do1),
    .busy      (busy1),
    .done      (done1)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: an absolute-cycle schedule of what each output must show.
  bit [L-1:0]        exp_en   [NCYC];
  bit [L-1:0][W-1:0] exp_data [NCYC];
  bit                exp_done [NCYC];
  bit                exp_busy [NCYC];
  bit                stream_mode = 1'b0;
  int                ready_from  = NEVER;
  int                cyc         = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < L; i++) v[i] = $urandom;
    return v;
  endfunction

  task automatic model_clear_from(input int c);
    for (int k = c; k < NCYC; k++) begin
      exp_en[k]   = '0;
      exp_data[k] = '0;
      exp_done[k] = 1'b0;
      exp_busy[k] = 1'b0;
    end
    stream_mode = 1'b0;
  endtask

  // One clock cycle: drive, sample mid-cycle, record the accept in the model.
  task automatic step(input logic v, input logic l, input vec_t d);
    bit exp_rdy;
    in_valid = v;
    in_last  = l;
    in_data  = d;
    @(negedge clk);
    exp_rdy = (cyc >= ready_from);
    check("in_ready",   128'(in_ready),   128'(exp_rdy));
    check("busy",       128'(busy),       128'(stream_mode || exp_busy[cyc]));
    check("done",       128'(done),       128'(exp_done[cyc]));
    check("enable_out", 128'(enable_out), 128'(exp_en[cyc]));
    check("data_out",   128'(data_out),   128'(exp_data[cyc]));
    if (v && exp_rdy) begin
      for (int i = 0; i < L; i++) begin
        exp_en[cyc+1+i][i]   = 1'b1;
        exp_data[cyc+1+i][i] = d[i];
      end
      if (l) begin
        stream_mode         = 1'b0;
        ready_from          = cyc + L;
        exp_done[cyc+L]     = 1'b1;
        for (int k = 1; k < L; k++) exp_busy[cyc+k] = 1'b1;
      end else begin
        stream_mode = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    rstn = 1'b0; rstn1 = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    v1 = 1'b0; l1 = 1'b0; d1 = '0;

    // ---- 1-lane build ----
    @(posedge clk); #1;
    check("l1_rst_ready", 128'(r1), 128'(1'b0));
    rstn1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b1; l1 = 1'b1; d1[0] = 32'hA5A5_0001;
    @(negedge clk);
    check("l1_ready_pre",  128'(r1),   128'(1'b1));
    check("l1_en_pre",     128'(en1),  128'(1'b0));
    @(posedge clk); #1;
    v1 = 1'b1; l1 = 1'b0; d1[0] = 32'h0000_BEEF;
    @(negedge clk);
    check("l1_en_t1",    128'(en1),   128'(1'b1));
    check("l1_data_t1",  128'(do1),   128'(32'hA5A5_0001));
    check("l1_done_t1",  128'(done1), 128'(1'b1));
    check("l1_ready_t1", 128'(r1),    128'(1'b1));
    check("l1_busy_t1",  128'(busy1), 128'(1'b0));
    @(posedge clk); #1;
    v1 = 1'b1; l1 = 1'b1; d1[0] = 32'h1234_5678;
    @(negedge clk);
    check("l1_data_b2b", 128'(do1),   128'(32'h0000_BEEF));
    check("l1_busy_str", 128'(busy1), 128'(1'b1));
    check("l1_done_str", 128'(done1), 128'(1'b0));
    check("l1_ready_s",  128'(r1),    128'(1'b1));
    @(posedge clk); #1;
    v1 = 1'b0; l1 = 1'b0;
    @(negedge clk);
    check("l1_data_last", 128'(do1),   128'(32'h1234_5678));
    check("l1_done_last", 128'(done1), 128'(1'b1));
    check("l1_busy_last", 128'(busy1), 128'(1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    check("l1_en_quiet", 128'(en1), 128'(1'b0));
    check("l1_data_0",   128'(do1), 128'(32'h0));
    @(posedge clk); #1;

    // ---- 4-lane build: reset state ----
    cyc = 0;
    model_clear_from(0);
    ready_from = NEVER;
    idle(2);
    rstn = 1'b1;
    ready_from = cyc + 1;
    idle(1);

    // Single last vector
    step(1'b1, 1'b1, {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000});
    idle(5);

    // Four back-to-back vectors, last on the fourth
    for (int k = 0; k < 4; k++) step(1'b1, (k == 3), rand_vec());
    idle(5);

    // Vector, bubble, last vector
    step(1'b1, 1'b0, rand_vec());
    idle(1);
    step(1'b1, 1'b1, rand_vec());
    idle(5);

    // in_last without in_valid is ignored
    step(1'b0, 1'b1, rand_vec());
    idle(1);

    // in_valid held through DRAIN; accept lands in the done cycle
    step(1'b1, 1'b1, rand_vec());
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, rand_vec());
    step(1'b1, 1'b1, rand_vec());
    idle(5);

    // Randomized traffic
    for (int k = 0; k < 200; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, rand_vec());
    step(1'b1, 1'b1, rand_vec());
    idle(6);

    // Reset at cycle 2 of a four-vector tile
    step(1'b1, 1'b0, rand_vec());
    step(1'b1, 1'b0, rand_vec());
    rstn = 1'b0;
    #1;
    check("rst_enable", 128'(enable_out), 128'(0));
    check("rst_data",   128'(data_out),   128'(0));
    check("rst_busy",   128'(busy),       128'(1'b0));
    check("rst_ready",  128'(in_ready),   128'(1'b0));
    check("rst_done",   128'(done),       128'(1'b0));
    model_clear_from(cyc);
    ready_from = NEVER;
    step(1'b1, 1'b0, rand_vec());
    step(1'b1, 1'b1, rand_vec());
    rstn = 1'b1;
    ready_from = cyc + 1;
    idle(7);

    // Fresh tile after the reset behaves normally
    step(1'b1, 1'b1, rand_vec());
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tri_skew_feeder.md
TRI_SKEW_FEEDER -- requirements
Module: tri_skew_feeder

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, width of one lane element.
REQ-002 SHALL have parameter TRI_LENGTH, default 16, lane count; legal range 1..64.
REQ-003 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream vector is present.
REQ-006 SHALL have port in_ready  output  1  block accepts a vector this cycle.
REQ-007 SHALL have port in_last  input  1  qualifies the final vector of a tile.
REQ-008 SHALL have port in_data  input  [TRI_LENGTH][BIT_WIDTH]  one unskewed row vector.
REQ-009 SHALL have port enable_out  output  [TRI_LENGTH]  per-lane valid toward the array edge.
REQ-010 SHALL have port data_out  output  [TRI_LENGTH][BIT_WIDTH]  per-lane skewed data.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  single-cycle tile-complete pulse.

Function
REQ-013 An accept SHALL occur in a cycle where in_valid and in_ready are both high; data is captured on that edge.
REQ-014 For an accept in cycle T, lane i SHALL present enable_out[i]=1 with data_out[i]=in_data[i] in cycle T+1+i.
REQ-015 A non-accept cycle SHALL inject a bubble: in lane i, cycle T+1+i, enable_out[i]=0 and data_out[i]=0.
REQ-016 data_out[i] SHALL be zero whenever enable_out[i] is zero.
REQ-017 There is no downstream backpressure; lanes SHALL shift every cycle unconditionally.
REQ-018 The FSM SHALL have states IDLE, STREAM, DRAIN.
REQ-019 IDLE SHALL go to STREAM on an accept without in_last, and to DRAIN on an accept with in_last, when TRI_LENGTH>1.
REQ-020 STREAM SHALL remain in STREAM on accepts without in_last and on idle cycles, and SHALL go to DRAIN on an accept with in_last.
REQ-021 in_ready SHALL be 1 in IDLE and STREAM and 0 in DRAIN.
REQ-022 On entering DRAIN, a down-counter of width clog2(TRI_LENGTH) SHALL load TRI_LENGTH-1 and decrement each cycle.
REQ-023 DRAIN SHALL return to IDLE when the counter reaches 1, so in_ready is low for exactly TRI_LENGTH-1 cycles (T+1..T+TRI_LENGTH-1).
REQ-024 done SHALL pulse in cycle T+TRI_LENGTH, concurrent with the last lane's final element and with in_ready returning high.
REQ-025 When TRI_LENGTH=1, an in_last accept SHALL return to IDLE with no DRAIN cycles and SHALL pulse done at T+1.
REQ-026 An accept in the same cycle that done is high SHALL be legal and SHALL start a new tile; its skew SHALL be independent of the previous tile.
REQ-027 in_last with in_valid low SHALL be ignored.

Reset
REQ-028 rstn low SHALL immediately clear state to IDLE, the counter to 0, all delay stages to enable=0 and data=0, and done to 0.
REQ-029 While rstn is low, in_ready SHALL be 0.
REQ-030 Reset mid-tile SHALL discard all in-flight elements; no enable_out is asserted for them after release.
REQ-031 in_ready SHALL be 1 on the first clk edge after rstn deasserts.

Structure
REQ-032 Package tri_pkg SHALL hold the FSM state enum (IDLE/STREAM/DRAIN) and default BIT_WIDTH/TRI_LENGTH constants.
REQ-033 A single sub-module, skew_lane (parameters DATA_WIDTH, DEPTH), SHALL implement one enable+data delay line; it SHALL be instantiated TRI_LENGTH times with DEPTH=i+1.
REQ-034 The FSM, counter and ready/busy/done logic SHALL reside in tri_skew_feeder.

Verification (TRI_LENGTH=4, BIT_WIDTH=32)
REQ-035 Single vector {A,B,C,D} with in_last, accepted at cycle 0 -> lane0=A at 1, lane1=B at 2, lane2=C at 3, lane3=D at 4; in_ready low cycles 1-3; done high at cycle 4.
REQ-036 Four back-to-back vectors V0..V3, last on V3 -> enable_out[3] high cycles 4-7 carrying V0[3]..V3[3]; done high at cycle 7.
REQ-037 V0, one idle cycle, then V1 with last -> each lane shows a one-cycle gap with enable=0 and data=0 between V0 and V1.
REQ-038 in_valid held high through DRAIN -> no accepts while in_ready=0; next accept occurs in the done cycle and lane0 outputs it one cycle later.
REQ-039 rstn asserted at cycle 2 of a four-vector tile -> all enable_out=0 immediately, busy=0, and no done pulse after release.
REQ-040 TRI_LENGTH=1 build with a single last vector -> data appears at cycle 1, done at cycle 1, in_ready never drops.
